// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory subsystem: arbiter FSM states,
// hold counter width and small helpers used by mem_arbiter and arb_pick.
package cpu_pkg;

  localparam int AW         = 10;
  localparam int DW         = 16;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  function automatic logic [HOLD_CNT_W-1:0] hold_inc(input logic [HOLD_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic arb_state_t own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational winner select for mem_arbiter; one-hot grant from
// the registered FSM state, current requests, hold count and last served port.
module arb_pick
  import cpu_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter bit RR_EN    = 1'b0
)(
  input  arb_state_t              state,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [HOLD_CNT_W-1:0]   hold_cnt,
  input  logic                    last_served,
  output logic [1:0]              gnt
);

  logic hold_hit;

  // >= keeps the guard effective if the count ran past the limit while alone
  assign hold_hit = (hold_cnt >= HOLD_CNT_W'(HOLD_MAX));

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0: begin
        if (req0 && !(req1 && hold_hit)) gnt = 2'b01;
        else if (req1)                   gnt = 2'b10;
      end
      OWN1: begin
        if (req1 && !(req0 && hold_hit)) gnt = 2'b10;
        else if (req0)                   gnt = 2'b01;
      end
      default: begin
        if (req0 && req1) gnt = (RR_EN && !last_served) ? 2'b10 : 2'b01;
        else              gnt = {req1, req0};
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the single-port program/data memory.
// Define ARB_RR_EN to resolve idle-state ties round-robin instead of port 0 first.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = cpu_pkg::AW,
  parameter int DW       = cpu_pkg::DW,
  parameter int HOLD_MAX = 4
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          lock0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t                 state, state_nxt;
  logic [HOLD_CNT_W-1:0]      hold_cnt, hold_nxt;
  logic                       last_served;
  logic [1:0]                 pick, gnt, req, lock, we, rd_vld;
  logic [1:0][AW-1:0]         addr;
  logic [1:0][DW-1:0]         wdata;
  logic                       sel, own;

  assign req   = {req1, req0};
  assign lock  = {lock1, lock0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  arb_pick #(.HOLD_MAX(HOLD_MAX), .RR_EN(RR_EN)) u_pick (
    .state       (state),
    .req0        (req0),
    .req1        (req1),
    .hold_cnt    (hold_cnt),
    .last_served (last_served),
    .gnt         (pick)
  );

  // No grant may escape while reset is held, even with requests pending
  assign gnt  = pick & {2{reset}};
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign sel  = gnt[1];
  assign own  = (state == OWN1);

  assign mem_en    = |gnt;
  assign mem_we    = mem_en & we[sel];
  assign mem_addr  = mem_en ? addr[sel]  : '0;
  assign mem_wdata = mem_en ? wdata[sel] : '0;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      OWN0, OWN1: begin
        if (gnt[own]) begin
          if (lock[own]) hold_nxt = hold_inc(hold_cnt);
          else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        end else if (|gnt) begin
          state_nxt = lock[sel] ? own_state(sel) : IDLE;
          // a starvation hand-over restarts the count; a plain release counts the new first grant
          hold_nxt  = (req[own] || !lock[sel]) ? '0 : HOLD_CNT_W'(1);
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        if (|gnt && lock[sel]) begin
          state_nxt = own_state(sel);
          hold_nxt  = HOLD_CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rd_vld   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rd_vld   <= gnt & ~we;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_served <= 1'b1;
    else if (|gnt)  last_served <= sel;
  end
`else
  assign last_served = 1'b1;
`endif

  assign rvalid0 = rd_vld[0];
  assign rvalid1 = rd_vld[1];
  assign rdata0  = rd_vld[0] ? mem_rdata : '0;
  assign rdata1  = rd_vld[1] ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 synchronous program/data memory between two requesters.
- Port 0 is the CPU fetch/operand/store path. Port 1 is the program loader / debug access port.
- Sits between the CPU and the memory. One access per clock. Short multi-access bursts are supported via a lock input, so a CPU fetch+operand sequence is not interleaved.
- Replaces the direct CPU-to-memory wiring.

Parameters:
AW, 10, address width (memory word address)
DW, 16, data width
HOLD_MAX, 4, max consecutive locked grants to one port while the other port is requesting; range 1..15

Ports:
clk  in  1  system clock, rising-edge only
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0  in  1  port 0 access request, held until granted
lock0  in  1  port 0 wants to keep ownership for its next request
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 access accepted this cycle
rvalid0  out  1  port 0 read data valid (cycle after a granted read)
rdata0  out  DW  port 0 read data
req1, lock1, we1, addr1, wdata1  in  1/1/1/AW/DW  port 1 equivalents
gnt1, rvalid1, rdata1  out  1/1/DW  port 1 equivalents
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; hold_cnt=0; last_served=1 (port 0 favoured first); rvalid pipeline is cleared.
  - All outputs are 0: gnt0/1, rvalid0/1, rdata0/1, mem_en, mem_we, mem_addr, mem_wdata.
  - Any read in flight is discarded; no rvalid is produced for it after reset releases.
- Grant is combinational from the registered state and the current req inputs. At most one gnt per cycle.
- When gntX=1:
  - mem_en=1, mem_we=weX, mem_addr=addrX, mem_wdata=wdataX in the same cycle.
  - The requester treats the access as taken at the rising edge and may change or drop req afterwards.
- When no gnt: mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
- Read latency is 1:
  - A granted read at edge t gives rvalidX=1 for the cycle after t, with rdataX=mem_rdata.
  - rdataX is 0 whenever rvalidX=0.
  - A write gives no rvalid.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE, only one req: grant that port. Go to OWNx if its lock=1, else stay in IDLE.
  - IDLE, both req: fixed priority, port 0 wins.
  - OWNx: port x has absolute priority while reqX=1. Each grant to x increments hold_cnt, saturating at 15.
  - OWNx exit on a granted access with lockX=0 -> IDLE; hold_cnt=0.
  - OWNx exit when reqX=0 -> IDLE. The other port may be granted in that same cycle (arbitrated as in IDLE).
  - Starvation guard: in OWNx with hold_cnt==HOLD_MAX and the other port requesting, the other port is granted instead. State goes to OWNy if lockY=1, else IDLE; hold_cnt=0.
  - If the other port is not requesting, x keeps being granted past HOLD_MAX.
- Simultaneous events: a request and its own release in the same cycle are handled as "grant, then leave OWNx". The reqX/lockX pair is sampled only in cycles where gntX=1.
- A requester must hold we/addr/wdata stable while req=1 and gnt=0.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: IDLE-state ties are resolved round-robin. The port not granted most recently wins. last_served updates on every grant.
- Undefined: fixed priority, port 0 wins ties. last_served is not implemented. Starvation of port 1 is bounded only while port 0 holds a lock.

Decomposition:
- Shared package cpu_pkg:
  - AW/DW constants.
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - HOLD_CNT_W = 4.
- One natural sub-module: arb_pick.
  - Pure combinational winner select from (state, req0, req1, hold_cnt, last_served).
  - Outputs a one-hot grant.
  - Instantiated once; the FSM and the rvalid pipeline stay in mem_arbiter.

Test Plan:
- Reset mid-read: port 0 read of addr 0x005 granted, reset=0 before the next edge -> rvalid0 never asserts; all outputs 0 until the first new grant.
- Lone read: port 1 read of addr 0x3FF, memory holds 0xBEEF -> gnt1 same cycle; rvalid1=1 and rdata1=0xBEEF exactly one cycle later; rvalid0 stays 0.
- Tie in IDLE, both req with lock=0 -> gnt0 first then gnt1 (fixed priority). With ARB_RR_EN after a port 0 grant -> gnt1 first.
- Locked burst: port 0 issues 3 locked reads at 0x010..0x012 while port 1 requests -> three consecutive gnt0, then gnt1 on the 4th cycle.
- Starvation guard, HOLD_MAX=4: port 0 lock held permanently with port 1 requesting -> gnt0 on 4 cycles, gnt1 on the 5th, then port 0 regrants.
- Write pass-through: port 1 write 0x1234 to 0x020, then port 0 read of 0x020 -> mem_we=1 during the write grant; rdata0=0x1234 on the rvalid0 cycle.
